// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and item config field positions for vend_txn_ctrl
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COLLECT,
    DISPENSE,
    CHANGE,
    REFUND
  } state_t;

  localparam int PRICE_LSB = 0;
  localparam int PRICE_MSB = 15;
  localparam int AVAIL_LSB = 16;
  localparam int AVAIL_MSB = 23;

endpackage

// File: rtl/vend_payout.sv
// rtl/vend_payout.sv - ready/valid coin beat generator that drains a credit value
module vend_payout #(
  parameter int CREDIT_W = 24,
  parameter int COIN_VAL = 5
) (
  input  logic                i_active,
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [15:0]         o_amt,
  output logic                o_beat,
  output logic [CREDIT_W-1:0] o_credit_nxt,
  output logic                o_done
);

  localparam logic [CREDIT_W-1:0] COIN = CREDIT_W'(COIN_VAL);

  logic [CREDIT_W-1:0] w_amt;

  // Beat value depends only on the held credit, so it stays stable while stalled.
  assign w_amt        = (i_credit < COIN) ? i_credit : COIN;
  assign o_valid      = i_active && (i_credit != '0);
  assign o_amt        = o_valid ? 16'(w_amt) : 16'd0;
  assign o_beat       = o_valid && i_ready;
  assign o_credit_nxt = i_credit - w_amt;
  assign o_done       = o_beat && (o_credit_nxt == '0);

endmodule

// File: rtl/vend_txn_ctrl.sv
// rtl/vend_txn_ctrl.sv - vending transaction FSM: lookup, credit, dispense, change/refund
// Optional audit counters are built when VEND_AUDIT_EN is defined.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_ITEMS    = 32,
  parameter int MAX_NOTE_VAL = 100,
  parameter int CREDIT_W     = 24,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int COIN_VAL     = 5,
  localparam int IW = $clog2(MAX_ITEMS),
  localparam int NW = $clog2(MAX_NOTE_VAL) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  input  logic [IW-1:0]       sel_item,
  input  logic [7:0]          sel_count,
  input  logic                cancel,
  input  logic                cur_valid,
  input  logic [NW-1:0]       cur_value,
  output logic                cur_reject,
  output logic [IW-1:0]       cfg_item,
  input  logic [31:0]         cfg_data,
  output logic                upd_valid,
  output logic [IW-1:0]       upd_item,
  output logic [7:0]          upd_count,
  output logic                disp_valid,
  input  logic                disp_ready,
  output logic [IW-1:0]       disp_item,
  output logic [7:0]          disp_count,
  output logic                chg_valid,
  input  logic                chg_ready,
  output logic [15:0]         chg_amt,
  output logic                err_sold_out,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
`ifdef VEND_AUDIT_EN
  ,
  output logic [31:0]         audit_sales,
  output logic [31:0]         audit_refunds
`endif
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t              r_state;
  logic                r_sel_prev;
  logic                r_sel_rise;
  logic [IW-1:0]       r_sel_item_p;
  logic [7:0]          r_sel_count_p;
  logic [IW-1:0]       r_item;
  logic [7:0]          r_count;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_total;
  logic [TMO_W-1:0]    r_tmo;

  logic [15:0]         w_price;
  logic [7:0]          w_avail;
  logic                w_lookup_fail;
  logic [CREDIT_W-1:0] w_total;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_credit_in;
  logic                w_tmo_hit;
  logic                w_abort;
  logic                w_disp_hs;
  logic                w_pay_active;
  logic                w_beat;
  logic                w_done;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_unused_cfg;

  assign w_price       = cfg_data[PRICE_MSB:PRICE_LSB];
  assign w_avail       = cfg_data[AVAIL_MSB:AVAIL_LSB];
  assign w_unused_cfg  = ^cfg_data[31:24];
  assign w_lookup_fail = (r_count == 8'd0) || (w_avail < r_count);
  assign w_total       = CREDIT_W'(r_count) * CREDIT_W'(w_price);

  // Credit as it stands after this cycle's note, saturating rather than wrapping.
  assign w_sum       = {1'b0, r_credit} + (CREDIT_W + 1)'(cur_value);
  assign w_credit_in = (r_state == COLLECT && cur_valid)
                       ? (w_sum[CREDIT_W] ? {CREDIT_W{1'b1}} : w_sum[CREDIT_W-1:0])
                       : r_credit;
  assign w_tmo_hit   = !cur_valid && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign w_abort     = cancel || w_tmo_hit;

  assign w_disp_hs    = (r_state == DISPENSE) && disp_ready;
  assign w_pay_active = (r_state == CHANGE) || (r_state == REFUND);

  vend_payout #(
    .CREDIT_W (CREDIT_W),
    .COIN_VAL (COIN_VAL)
  ) u_payout (
    .i_active     (w_pay_active),
    .i_credit     (r_credit),
    .i_ready      (chg_ready),
    .o_valid      (chg_valid),
    .o_amt        (chg_amt),
    .o_beat       (w_beat),
    .o_credit_nxt (w_credit_nxt),
    .o_done       (w_done)
  );

  assign cur_reject   = cur_valid && (r_state != COLLECT);
  assign cfg_item     = r_item;
  assign err_sold_out = (r_state == LOOKUP) && w_lookup_fail;
  assign disp_valid   = (r_state == DISPENSE);
  assign disp_item    = disp_valid ? r_item : '0;
  assign disp_count   = disp_valid ? r_count : 8'd0;
  assign upd_valid    = w_disp_hs;
  assign upd_item     = w_disp_hs ? r_item : '0;
  assign upd_count    = w_disp_hs ? r_count : 8'd0;
  assign busy         = (r_state != IDLE);
  assign credit       = r_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sel_prev    <= 1'b0;
      r_sel_rise    <= 1'b0;
      r_sel_item_p  <= '0;
      r_sel_count_p <= 8'd0;
      r_item        <= '0;
      r_count       <= 8'd0;
      r_credit      <= '0;
      r_total       <= '0;
      r_tmo         <= '0;
    end else begin
      r_sel_prev <= sel_valid;
      r_sel_rise <= sel_valid && !r_sel_prev;
      if (sel_valid && !r_sel_prev) begin
        r_sel_item_p  <= sel_item;
        r_sel_count_p <= sel_count;
      end
      case (r_state)
        IDLE: begin
          r_tmo <= '0;
          if (r_sel_rise) begin
            r_item  <= r_sel_item_p;
            r_count <= r_sel_count_p;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_tmo <= '0;
          if (w_lookup_fail) begin
            r_state <= IDLE;
          end else begin
            r_total <= w_total;
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          r_credit <= w_credit_in;
          r_tmo    <= (cur_valid || w_abort) ? '0 : r_tmo + TMO_W'(1);
          // Abort outranks a completing note; that note joins the refund.
          if (w_abort) begin
            r_state <= (w_credit_in != '0) ? REFUND : IDLE;
          end else if (w_credit_in >= r_total) begin
            r_state <= DISPENSE;
          end
        end
        DISPENSE: begin
          if (disp_ready) begin
            r_credit <= r_credit - r_total;
            r_state  <= (r_credit != r_total) ? CHANGE : IDLE;
          end
        end
        CHANGE, REFUND: begin
          if (w_beat) r_credit <= w_credit_nxt;
          if (w_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef VEND_AUDIT_EN
  logic [31:0] r_audit_sales;
  logic [31:0] r_audit_refunds;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_audit_sales   <= 32'd0;
      r_audit_refunds <= 32'd0;
    end else begin
      if (w_disp_hs) r_audit_sales <= r_audit_sales + 32'(r_count);
      if (r_state == REFUND && w_done) r_audit_refunds <= r_audit_refunds + 32'd1;
    end
  end

  assign audit_sales   = r_audit_sales;
  assign audit_refunds = r_audit_refunds;
`endif

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb/tb_vend_txn_ctrl.sv - self-checking bench for vend_txn_ctrl with a transaction-level model
module tb_vend_txn_ctrl;

  localparam int IW  = 5;
  localparam int NW  = 8;
  localparam int CW  = 24;
  localparam int TMO = 1000;
  localparam int COIN = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel_valid = 1'b0;
  logic [IW-1:0] sel_item = '0;
  logic [7:0]    sel_count = 8'd0;
  logic          cancel = 1'b0;
  logic          cur_valid = 1'b0;
  logic [NW-1:0] cur_value = '0;
  logic          cur_reject;
  logic [IW-1:0] cfg_item;
  logic [31:0]   cfg_data;
  logic          upd_valid;
  logic [IW-1:0] upd_item;
  logic [7:0]    upd_count;
  logic          disp_valid;
  logic          disp_ready = 1'b1;
  logic [IW-1:0] disp_item;
  logic [7:0]    disp_count;
  logic          chg_valid;
  logic          chg_ready = 1'b1;
  logic [15:0]   chg_amt;
  logic          err_sold_out;
  logic          busy;
  logic [CW-1:0] credit;

  logic [31:0] cfg_mem [0:31];
  assign cfg_data = cfg_mem[cfg_item];

  vend_txn_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .sel_count    (sel_count),
    .cancel       (cancel),
    .cur_valid    (cur_valid),
    .cur_value    (cur_value),
    .cur_reject   (cur_reject),
    .cfg_item     (cfg_item),
    .cfg_data     (cfg_data),
    .upd_valid    (upd_valid),
    .upd_item     (upd_item),
    .upd_count    (upd_count),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_item    (disp_item),
    .disp_count   (disp_count),
    .chg_valid    (chg_valid),
    .chg_ready    (chg_ready),
    .chg_amt      (chg_amt),
    .err_sold_out (err_sold_out),
    .busy         (busy),
    .credit       (credit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 0: both ready, 1: random, 2: dispenser stalled, 3: coin mech stalled
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin disp_ready = 1'b1; chg_ready = 1'b1; end
      1: begin disp_ready = 1'($urandom_range(0, 1)); chg_ready = 1'($urandom_range(0, 1)); end
      2: begin disp_ready = 1'b0; chg_ready = 1'b1; end
      default: begin disp_ready = 1'b1; chg_ready = 1'b0; end
    endcase
  end

  int n_upd = 0, n_disp = 0, n_err = 0, n_rej = 0;
  logic [IW-1:0] last_disp_item = '0;
  logic [7:0]    last_disp_count = 8'd0;
  int beats[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (upd_valid) n_upd++;
      if (disp_valid && disp_ready) begin
        n_disp++;
        last_disp_item  = disp_item;
        last_disp_count = disp_count;
      end
      if (err_sold_out) n_err++;
      if (cur_reject) n_rej++;
      if (chg_valid && chg_ready) beats.push_back(int'(chg_amt));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_item(input int idx, input int price, input int avail);
    cfg_mem[idx] = {8'd0, 8'(avail), 16'(price)};
  endtask

  task automatic do_select(input int item, input int count);
    sel_item  = IW'(item);
    sel_count = 8'(count);
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic feed(input int v);
    cur_valid = 1'b1;
    cur_value = NW'(v);
    tick();
    cur_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        cyc = i;
        return;
      end
      tick();
    end
  endtask

  // Expected payout: repeated COIN_VAL beats, final beat takes what is left.
  function automatic bit beats_match(input int base, input int rem);
    int i;
    int amt;
    i = base;
    while (rem > 0) begin
      amt = (rem < COIN) ? rem : COIN;
      if (i >= beats.size()) return 1'b0;
      if (beats[i] != amt) return 1'b0;
      rem -= amt;
      i++;
    end
    return (i == beats.size());
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({cur_reject, upd_valid, disp_valid, chg_valid, err_sold_out, busy} !== 6'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {cur_reject, upd_valid, disp_valid, chg_valid, err_sold_out, busy});
    end
    checks++;
    if ({cfg_item, upd_item, upd_count, disp_item, disp_count, chg_amt} !== '0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 0",
               {cfg_item, upd_item, upd_count, disp_item, disp_count, chg_amt});
    end
    checks++;
    if (credit !== '0) begin
      errors++;
      $display("FAIL reset_credit: got %0d expected 0", credit);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vend_change();
    int u0, d0, b0, c;
    u0 = n_upd; d0 = n_disp; b0 = beats.size();
    set_item(3, 20, 5);
    do_select(3, 2);
    feed(10);
    feed(10);
    cur_valid = 1'b1;
    cur_value = NW'(50);
    @(negedge clk);
    checks++;
    if (cur_reject !== 1'b0) begin
      errors++;
      $display("FAIL vend_note_accept: got cur_reject=%b expected 0", cur_reject);
    end
    tick();
    cur_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (disp_valid !== 1'b1 || disp_item !== IW'(3) || disp_count !== 8'd2) begin
      errors++;
      $display("FAIL vend_disp_latency: got valid=%b item=%0d count=%0d expected 1 3 2",
               disp_valid, disp_item, disp_count);
    end
    wait_idle(c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL vend_idle: got busy timeout expected return to IDLE");
    end
    checks++;
    if (n_upd - u0 != 1 || n_disp - d0 != 1) begin
      errors++;
      $display("FAIL vend_upd_pulse: got upd=%0d disp=%0d expected 1 1", n_upd - u0, n_disp - d0);
    end
    checks++;
    if (!beats_match(b0, 70 - 40)) begin
      errors++;
      $display("FAIL vend_change_beats: got %0d beats expected 6 beats of 5", beats.size() - b0);
    end
    checks++;
    if (credit !== '0) begin
      errors++;
      $display("FAIL vend_credit_end: got %0d expected 0", credit);
    end
  endtask

  task automatic test_sold_out();
    int e0, d0, c;
    d0 = n_disp;
    set_item(7, 10, 1);
    sel_item = IW'(7); sel_count = 8'd2; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (err_sold_out !== 1'b1) begin
      errors++;
      $display("FAIL soldout_pulse: got %b expected 1", err_sold_out);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_sold_out !== 1'b0) begin
      errors++;
      $display("FAIL soldout_idle: got busy=%b err=%b expected 0 0", busy, err_sold_out);
    end
    e0 = n_err;
    do_select(7, 0);
    checks++;
    if (n_err - e0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL soldout_zero_qty: got err=%0d busy=%b expected 1 0", n_err - e0, busy);
    end
    e0 = n_err;
    do_select(7, 1);
    feed(10);
    wait_idle(c);
    checks++;
    if (n_err != e0 || n_disp - d0 != 1 || c < 0) begin
      errors++;
      $display("FAIL soldout_exact_avail: got err=%0d disp=%0d expected 0 1", n_err - e0, n_disp - d0);
    end
  endtask

  task automatic test_timeout();
    int u0, d0, b0, c, w;
    u0 = n_upd; d0 = n_disp; b0 = beats.size();
    set_item(9, 30, 3);
    do_select(9, 1);
    feed(20);
    c = 0;
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clk);
      if (chg_valid) break;
      tick();
      c++;
    end
    checks++;
    if (c != TMO) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d expected %0d", c, TMO);
    end
    wait_idle(w);
    checks++;
    if (!beats_match(b0, 20) || w < 0) begin
      errors++;
      $display("FAIL timeout_refund: got %0d beats expected 4 beats of 5", beats.size() - b0);
    end
    checks++;
    if (n_upd != u0 || n_disp != d0) begin
      errors++;
      $display("FAIL timeout_no_disp: got upd=%0d disp=%0d expected 0 0", n_upd - u0, n_disp - d0);
    end
  endtask

  task automatic test_cancel();
    int d0, b0, c;
    d0 = n_disp; b0 = beats.size();
    set_item(10, 10, 2);
    do_select(10, 1);
    feed(7);
    cancel = 1'b1;
    cur_valid = 1'b1;
    cur_value = NW'(5);
    tick();
    cancel = 1'b0;
    cur_valid = 1'b0;
    wait_idle(c);
    checks++;
    if (!beats_match(b0, 12) || n_disp != d0 || c < 0) begin
      errors++;
      $display("FAIL cancel_refund: got %0d beats disp=%0d expected 5,5,2 and 0", beats.size() - b0, n_disp - d0);
    end
    b0 = beats.size();
    do_select(10, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || beats.size() != b0) begin
      errors++;
      $display("FAIL cancel_no_credit: got busy=%b beats=%0d expected 0 0", busy, beats.size() - b0);
    end
  endtask

  task automatic test_disp_stall();
    int u0, b0, c;
    bit note;
    u0 = n_upd; b0 = beats.size();
    rdy_mode = 2;
    tick();
    set_item(12, 20, 4);
    do_select(12, 1);
    feed(20);
    for (int i = 0; i < 10; i++) begin
      note = (i % 3 == 0);
      cur_valid = note;
      cur_value = NW'(10);
      @(negedge clk);
      checks++;
      if (disp_valid !== 1'b1 || disp_item !== IW'(12) || disp_count !== 8'd1 || upd_valid !== 1'b0
          || cur_reject !== note || credit !== CW'(20)) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b item=%0d count=%0d upd=%b rej=%b credit=%0d expected 1 12 1 0 %b 20",
                 disp_valid, disp_item, disp_count, upd_valid, cur_reject, credit, note);
      end
      tick();
    end
    cur_valid = 1'b0;
    rdy_mode = 0;
    wait_idle(c);
    checks++;
    if (n_upd - u0 != 1 || beats.size() != b0 || credit !== '0 || c < 0) begin
      errors++;
      $display("FAIL stall_release: got upd=%0d beats=%0d credit=%0d expected 1 0 0",
               n_upd - u0, beats.size() - b0, credit);
    end
  endtask

  task automatic test_reset_mid_change();
    rdy_mode = 3;
    tick();
    set_item(14, 5, 3);
    do_select(14, 1);
    feed(50);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (chg_valid !== 1'b1 || chg_amt !== 16'd5 || credit !== CW'(45)) begin
      errors++;
      $display("FAIL midchg_setup: got valid=%b amt=%0d credit=%0d expected 1 5 45", chg_valid, chg_amt, credit);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({chg_valid, disp_valid, upd_valid, err_sold_out, busy, cur_reject} !== 6'd0
        || chg_amt !== 16'd0 || credit !== '0 || cfg_item !== '0) begin
      errors++;
      $display("FAIL midchg_reset: got flags=%b amt=%0d credit=%0d expected 0",
               {chg_valid, disp_valid, upd_valid, err_sold_out, busy, cur_reject}, chg_amt, credit);
    end
    tick();
    rst = 1'b0;
    rdy_mode = 0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || chg_valid !== 1'b0 || credit !== '0) begin
      errors++;
      $display("FAIL midchg_after: got busy=%b chg=%b credit=%0d expected 0 0 0", busy, chg_valid, credit);
    end
  endtask

  task automatic test_random();
    int item, price, avail, count, total, paid, v, c;
    int u0, d0, e0, r0, b0;
    rdy_mode = 1;
    for (int t = 0; t < 30; t++) begin
      item  = $urandom_range(0, 31);
      price = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
      avail = $urandom_range(0, 8);
      count = $urandom_range(0, 5);
      set_item(item, price, avail);
      u0 = n_upd; d0 = n_disp; e0 = n_err; r0 = n_rej; b0 = beats.size();
      do_select(item, count);
      if (count == 0 || avail < count) begin
        wait_idle(c);
        checks++;
        if (n_err - e0 != 1 || n_disp != d0 || c < 0) begin
          errors++;
          $display("FAIL rand_soldout[%0d]: got err=%0d disp=%0d expected 1 0", t, n_err - e0, n_disp - d0);
        end
      end else begin
        total = count * price;
        paid  = 0;
        while (paid < total) begin
          v = $urandom_range(1, 100);
          feed(v);
          paid += v;
        end
        wait_idle(c);
        checks++;
        if (c < 0 || n_disp - d0 != 1 || n_upd - u0 != 1 || last_disp_item !== IW'(item)
            || last_disp_count !== 8'(count) || n_rej != r0) begin
          errors++;
          $display("FAIL rand_disp[%0d]: got disp=%0d upd=%0d item=%0d count=%0d rej=%0d expected 1 1 %0d %0d 0",
                   t, n_disp - d0, n_upd - u0, last_disp_item, last_disp_count, n_rej - r0, item, count);
        end
        checks++;
        if (!beats_match(b0, paid - total) || credit !== '0) begin
          errors++;
          $display("FAIL rand_change[%0d]: got %0d beats credit=%0d expected change %0d", t,
                   beats.size() - b0, credit, paid - total);
        end
      end
    end
    rdy_mode = 0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) cfg_mem[i] = 32'd0;
    test_reset();
    test_vend_change();
    test_sold_out();
    test_timeout();
    test_cancel();
    test_disp_stall();
    test_random();
    test_reset_mid_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
Next-generation vending transaction controller. It replaces the single-shot compare/dispense logic with a full transaction FSM covering:
- selection capture and inventory lookup
- credit accumulation with inactivity timeout
- user cancel and refund
- ready/valid handshaked dispense
- multi-beat change payout

It sits between the user-facing currency/select inputs and the item config store (combinational cfg read, one-cycle update pulse).

Parameters:
MAX_ITEMS, 32, number of item slots; IW = $clog2(MAX_ITEMS)
MAX_NOTE_VAL, 100, largest single note value; NW = $clog2(MAX_NOTE_VAL)+1
CREDIT_W, 24, width of credit accumulator and transaction total
TIMEOUT_CYC, 1000, idle cycles in COLLECT before auto-refund
COIN_VAL, 5, value paid per change/refund beat

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
sel_valid  in  1  item select strobe (level; rising edge sampled)
sel_item  in  IW  selected item code
sel_count  in  8  quantity requested
cancel  in  1  user cancel request (level)
cur_valid  in  1  currency note present this cycle
cur_value  in  NW  note value
cur_reject  out  1  pulse: note not accepted
cfg_item  out  IW  item index driven to config store
cfg_data  in  32  combinational item cfg: [15:0] price, [23:16] available
upd_valid  out  1  one-cycle inventory update pulse
upd_item  out  IW  item to update
upd_count  out  8  quantity dispensed
disp_valid  out  1  dispense request
disp_ready  in  1  dispenser accepts
disp_item  out  IW  item to dispense
disp_count  out  8  quantity to dispense
chg_valid  out  1  coin payout request
chg_ready  in  1  coin mechanism accepts
chg_amt  out  16  value of this payout beat
err_sold_out  out  1  pulse: insufficient inventory or zero quantity
busy  out  1  high in any state except IDLE
credit  out  CREDIT_W  current accumulated credit

Behaviour:
Reset (rst high, async):
- state IDLE; credit 0; timeout counter 0.
- All outputs 0, except cfg_item, which is 0 as well.

Stimulus rules:
- Select uses a rising-edge detect on sel_valid, registered internally.
- cur_valid is sampled every cycle it is high; each high cycle counts as one note.

IDLE:
- On sel rise: latch item/count, go to LOOKUP.
- Notes are rejected (cur_reject=1 the same cycle as the note, registered output one cycle later is NOT allowed; it is combinational from the state register).

LOOKUP (1 cycle, cfg_item = latched item):
- count==0 or cfg_data[23:16] < count: err_sold_out pulse, go to IDLE.
- Otherwise: total = count*price (24-bit unsigned), latch total, go to COLLECT.

COLLECT:
- Each note: credit += cur_value, saturating at 2^CREDIT_W-1; the timeout counter clears.
- When credit >= total: go to DISPENSE. This is checked every cycle, so total==0 dispenses on the cycle after entry.
- cancel: go to REFUND if credit>0, else IDLE.
- Timeout counter reaches TIMEOUT_CYC-1 with no note: same action as cancel.
- cancel together with a note that completes payment: cancel wins and the note is added to the refund.
- sel edge is ignored outside IDLE.

DISPENSE:
- disp_valid held with stable item/count until disp_ready.
- On the handshake cycle: upd_valid pulses for exactly one cycle; credit -= total; go to CHANGE if the remainder >0, else IDLE.
- Notes arriving here are rejected. cancel is ignored.

CHANGE and REFUND:
- Same payout engine. Each beat: chg_amt = min(COIN_VAL, credit).
- On chg_valid & chg_ready: credit -= chg_amt.
- Go to IDLE when credit reaches 0. A final partial beat is allowed.
- chg_valid/chg_amt are stable while not ready. Notes are rejected.

Latency:
- sel rise to LOOKUP: 2 cycles.
- Paying note to disp_valid: 1 cycle.

Optional Feature:
VEND_AUDIT_EN:
- When defined, adds outputs audit_sales[31:0] (+= disp_count per dispense handshake) and audit_refunds[31:0] (+= 1 per completed REFUND). Both are cleared by rst and wrap silently.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package vend_pkg holds:
  - state enum {IDLE, LOOKUP, COLLECT, DISPENSE, CHANGE, REFUND}
  - cfg field localparams PRICE_LSB=0, PRICE_MSB=15, AVAIL_LSB=16, AVAIL_MSB=23
- One sub-module, vend_payout: credit-draining beat generator with ready/valid, shared by CHANGE and REFUND.

Test Plan:
- Item 3 cfg price 20, avail 5; sel count 2; notes 10,10,50 → disp_valid item 3 count 2; upd_valid single pulse; change beats 5,5,5,5,5,5; credit 0; back to IDLE.
- Avail 1, sel count 2 → err_sold_out pulse 2 cycles after sel edge; no disp_valid; busy low next cycle.
- Price 30; note 20, then TIMEOUT_CYC idle cycles → REFUND beats 5×4; no upd_valid.
- Price 10; note 7, then cancel asserted together with note 5 → refund total 12 as beats 5,5,2; no dispense.
- disp_ready held low 10 cycles → disp_valid/item/count stable; notes during wait give cur_reject=1; exactly one upd_valid after ready.
- rst asserted mid-CHANGE with chg_valid high → all outputs 0 immediately; credit 0; state IDLE.
